countdown_timer_param: RTL and testbench
========================================

Name: countdown_timer_param

Overview:
- Parametrised successor to the minute/second countdown block.
- Single-clock BCD mm:ss countdown timer with an internal prescaler, so it needs no external pulse chain.
- Adds a seconds preset, one-shot and auto-reload modes, pause/resume, expiry pulse, warning window and load validation.
- Sits between the front-panel load/enable controls and the 7-segment display driver.

Parameters:
- DIV, 100000000, clk cycles per 1 s tick (DIV >= 2).
- RST_MIN, 8'h01, BCD minutes value loaded at reset (seconds reset to 8'h00).
- WARN_SEC, 10, warn window in seconds, legal range 0..59.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous reset, active-high (asserted = 1, despite the name).
- cnt_en  in  1  run when 1, pause when 0.
- load  in  1  one-cycle strobe: capture min_init/sec_init.
- mode  in  1  0 = one-shot, 1 = auto-reload; sampled at each expiry.
- min_init  in  8  BCD minutes preset, 00..99.
- sec_init  in  8  BCD seconds preset, 00..59.
- xq  out  8  BCD minutes remaining.
- xh  out  8  BCD seconds remaining.
- running  out  1  state == RUN.
- done  out  1  state == DONE.
- expire  out  1  one-cycle pulse at each expiry.
- warn  out  1  1 when xq == 00, 0 < xh <= WARN_SEC, and state is RUN or PAUSE.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Priority per edge: rst_n > load > tick/decrement > cnt_en state change.
- Reset values:
  - xq = RST_MIN, xh = 00.
  - Shadow registers = RST_MIN:00.
  - prescaler = 0, state = IDLE.
  - running = 0, done = 0, expire = 0, load_err = 0, warn = 0.
- States: IDLE, RUN, PAUSE, DONE.
- Load validation:
  - Rejected when any BCD nibble > 9, or sec_init tens > 5.
  - Rejected load: load_err = 1 for one cycle; counters, shadow registers and state are unchanged.
  - Accepted load, from any state: xq/xh and the shadow registers take the presets, prescaler = 0, state = IDLE, and any same-cycle tick is discarded.
- Transitions:
  - IDLE -> RUN when cnt_en = 1 and value != 00:00.
  - IDLE -> DONE when cnt_en = 1 and value == 00:00; expire is not pulsed.
  - RUN -> PAUSE when cnt_en = 0.
  - PAUSE -> RUN when cnt_en = 1.
  - DONE holds until load or reset; cnt_en is ignored in DONE.
- Prescaler:
  - Increments only in RUN; holds in PAUSE; cleared in IDLE, in DONE and on load.
  - Tick = (prescaler == DIV-1) in RUN. Prescaler then wraps to 0.
  - First decrement lands DIV cycles after the first RUN cycle, then every DIV cycles.
  - If cnt_en drops on a tick cycle, the tick still applies and the state moves to PAUSE.
- Decrement on tick, BCD arithmetic:
  - Seconds ones != 0: ones - 1.
  - Seconds ones == 0 and tens != 0: ones = 9, tens - 1.
  - xh == 00 and xq != 00: xq BCD decrement, xh = 59. Minutes wrap the same way (e.g. 10 -> 09).
- Expiry: the tick taking 00:01 to 00:00.
  - mode = 0: xq:xh = 00:00, state = DONE, expire = 1 on the same edge.
  - mode = 1: xq:xh = shadow values (not 00:00), prescaler = 0, state stays RUN, expire = 1.
  - Auto-reload with a shadow of 00:00: behaves as one-shot.
- Outputs:
  - All outputs are registered except warn.
  - warn is combinational from registered xq/xh/state; seconds are compared in binary (tens*10 + ones).
  - expire and load_err never exceed one cycle.
  - expire is never asserted in IDLE.

Test Plan:
- Reset, DIV = 4, RST_MIN = 8'h01, cnt_en = 0: rst_n = 1 for 2 cycles -> xq = 8'h01, xh = 8'h00, all flags 0, state IDLE.
- Load 01:05, cnt_en = 1 -> xh steps 04, 03 ... every 4 cycles. 01:00 appears 20 cycles after RUN entry, 00:59 4 cycles later. running = 1 throughout.
- Load 00:03, mode = 0, run:
  - warn = 1 from the first RUN cycle while value <= 00:10.
  - 00:00 at cycle 12: expire = 1 for exactly one cycle, done = 1, running = 0, warn = 0.
  - Value holds 00:00 for 20 further cycles.
- Load 00:02, mode = 1, run -> at cycle 8 value = 00:02 and expire pulses; at cycle 16 a second pulse. done stays 0.
- Pause: run from 00:05, drop cnt_en for 10 cycles after 2 prescaler counts -> value frozen. On resume, the next tick arrives after 2 more cycles (prescaler preserved).
- Load edge cases:
  - sec_init = 8'h7A -> load_err pulses 1 cycle; value and state are unchanged.
  - Valid load on a tick cycle -> presets win and no decrement occurs.
  - Reset asserted mid-RUN -> RST_MIN:00, IDLE on the next edge.

Source files
------------

// File: rtl/countdown_timer_param.sv
// countdown_timer_param: BCD mm:ss countdown with an internal 1 s prescaler,
// one-shot / auto-reload expiry, pause/resume, warning window and load checks.
module countdown_timer_param #(
  parameter int         DIV      = 100000000,
  parameter logic [7:0] RST_MIN  = 8'h01,
  parameter int         WARN_SEC = 10
) (
  input  logic       clk,
  input  logic       rst_n,     // active-high synchronous reset
  input  logic       cnt_en,
  input  logic       load,
  input  logic       mode,
  input  logic [7:0] min_init,
  input  logic [7:0] sec_init,
  output logic [7:0] xq,
  output logic [7:0] xh,
  output logic       running,
  output logic       done,
  output logic       expire,
  output logic       warn,
  output logic       load_err
);

  localparam int            PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TOP = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state, state_nx;
  logic [7:0]    xq_nx, xh_nx;
  logic [7:0]    sh_min, sh_sec, sh_min_nx, sh_sec_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          expire_nx, load_err_nx;

  logic          load_ok, tick, at_one, shadow_zero;
  logic [6:0]    sec_bin;

  // Two-digit BCD decrement; callers guarantee the value is non-zero.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] != 4'd0) return {v[7:4], v[3:0] - 4'd1};
    else                return {v[7:4] - 4'd1, 4'd9};
  endfunction

  assign load_ok = (min_init[7:4] <= 4'd9) && (min_init[3:0] <= 4'd9) &&
                   (sec_init[7:4] <= 4'd5) && (sec_init[3:0] <= 4'd9);

  assign tick        = (state == RUN) && (presc == TOP);
  assign at_one      = (xq == 8'h00) && (xh == 8'h01);
  assign shadow_zero = (sh_min == 8'h00) && (sh_sec == 8'h00);

  // Warning window compares seconds in binary so WARN_SEC is a plain integer.
  assign sec_bin  = 7'(xh[7:4]) * 7'd10 + 7'(xh[3:0]);
  assign warn     = (xq == 8'h00) && (sec_bin != 7'd0) && (sec_bin <= 7'(WARN_SEC)) &&
                    ((state == RUN) || (state == PAUSE));
  assign running  = (state == RUN);
  assign done     = (state == DONE);

  // Register update: reset, otherwise take the next-state values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state    <= IDLE;
      xq       <= RST_MIN;
      xh       <= 8'h00;
      sh_min   <= RST_MIN;
      sh_sec   <= 8'h00;
      presc    <= '0;
      expire   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state    <= state_nx;
      xq       <= xq_nx;
      xh       <= xh_nx;
      sh_min   <= sh_min_nx;
      sh_sec   <= sh_sec_nx;
      presc    <= presc_nx;
      expire   <= expire_nx;
      load_err <= load_err_nx;
    end
  end

  // Next state and datapath: load beats tick, tick beats the cnt_en state change.
  always_comb begin
    state_nx    = state;
    xq_nx       = xq;
    xh_nx       = xh;
    sh_min_nx   = sh_min;
    sh_sec_nx   = sh_sec;
    presc_nx    = presc;
    expire_nx   = 1'b0;
    load_err_nx = 1'b0;
    if (load) begin
      // A rejected load freezes everything for the cycle, including the prescaler.
      if (load_ok) begin
        xq_nx     = min_init;
        xh_nx     = sec_init;
        sh_min_nx = min_init;
        sh_sec_nx = sec_init;
        presc_nx  = '0;
        state_nx  = IDLE;
      end else begin
        load_err_nx = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          presc_nx = '0;
          if (cnt_en) state_nx = ((xq == 8'h00) && (xh == 8'h00)) ? DONE : RUN;
        end
        RUN: begin
          if (tick) begin
            presc_nx = '0;
            if (at_one) begin
              expire_nx = 1'b1;
              if (mode && !shadow_zero) begin
                xq_nx = sh_min;
                xh_nx = sh_sec;
              end else begin
                xq_nx    = 8'h00;
                xh_nx    = 8'h00;
                state_nx = DONE;
              end
            end else if (xh != 8'h00) begin
              xh_nx = bcd_dec(xh);
            end else begin
              xq_nx = bcd_dec(xq);
              xh_nx = 8'h59;
            end
          end else begin
            presc_nx = presc + 1'b1;
          end
          // Pause still lets a same-cycle tick land; a one-shot expiry wins.
          if (!cnt_en && (state_nx == RUN)) state_nx = PAUSE;
        end
        PAUSE: begin
          if (cnt_en) state_nx = RUN;
        end
        DONE: begin
          presc_nx = '0;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_countdown_timer_param.sv
// Bench for countdown_timer_param: a seconds-based reference model pushes the
// expected outputs for every driven cycle; they are popped after the edge.
module tb_countdown_timer_param;

  localparam int         DIV      = 4;
  localparam logic [7:0] RST_MIN  = 8'h01;
  localparam int         WARN_SEC = 10;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1, cnt_en = 1'b0, load = 1'b0, mode = 1'b0;
  logic [7:0] min_init = 8'h00, sec_init = 8'h00;
  logic [7:0] xq, xh;
  logic       running, done, expire, warn, load_err;

  typedef struct packed {
    logic [7:0] xq;
    logic [7:0] xh;
    logic       running;
    logic       done;
    logic       expire;
    logic       warn;
    logic       load_err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // model state: remaining time as plain seconds
  int   m_val, m_shadow, m_presc, m_st;
  logic m_exp, m_lerr;

  countdown_timer_param #(.DIV(DIV), .RST_MIN(RST_MIN), .WARN_SEC(WARN_SEC)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_en(cnt_en), .load(load), .mode(mode),
    .min_init(min_init), .sec_init(sec_init), .xq(xq), .xh(xh),
    .running(running), .done(done), .expire(expire), .warn(warn), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic model(input logic r, input logic en, input logic ld, input logic md,
                       input logic [7:0] mi, input logic [7:0] se);
    int mt, mo, st, so;
    if (r) begin
      m_val    = (int'(RST_MIN[7:4]) * 10 + int'(RST_MIN[3:0])) * 60;
      m_shadow = m_val;
      m_presc  = 0;
      m_st     = S_IDLE;
      m_exp    = 1'b0;
      m_lerr   = 1'b0;
      return;
    end
    m_exp  = 1'b0;
    m_lerr = 1'b0;
    if (ld) begin
      mt = int'(mi[7:4]); mo = int'(mi[3:0]); st = int'(se[7:4]); so = int'(se[3:0]);
      if (mt <= 9 && mo <= 9 && st <= 5 && so <= 9) begin
        m_val    = (mt * 10 + mo) * 60 + st * 10 + so;
        m_shadow = m_val;
        m_presc  = 0;
        m_st     = S_IDLE;
      end else begin
        m_lerr = 1'b1;
      end
      return;
    end
    case (m_st)
      S_IDLE: begin
        m_presc = 0;
        if (en) m_st = (m_val == 0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (m_presc == DIV - 1) begin
          m_presc = 0;
          if (m_val == 1) begin
            m_exp = 1'b1;
            if (md && m_shadow != 0) m_val = m_shadow;
            else begin m_val = 0; m_st = S_DONE; end
          end else begin
            m_val = m_val - 1;
          end
        end else begin
          m_presc = m_presc + 1;
        end
        if (!en && m_st == S_RUN) m_st = S_PAUSE;
      end
      S_PAUSE: if (en) m_st = S_RUN;
      default: m_presc = 0;
    endcase
  endtask

  // Drive one cycle of stimulus, queue the model's prediction, compare after the edge.
  task automatic step(input logic r, input logic en, input logic ld, input logic md,
                      input logic [7:0] mi, input logic [7:0] se);
    exp_t e;
    rst_n = r; cnt_en = en; load = ld; mode = md; min_init = mi; sec_init = se;
    model(r, en, ld, md, mi, se);
    e.xq       = to_bcd(m_val / 60);
    e.xh       = to_bcd(m_val % 60);
    e.running  = (m_st == S_RUN);
    e.done     = (m_st == S_DONE);
    e.expire   = m_exp;
    e.load_err = m_lerr;
    e.warn     = (m_val / 60 == 0) && (m_val % 60 > 0) && (m_val % 60 <= WARN_SEC) &&
                 (m_st == S_RUN || m_st == S_PAUSE);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_xq", xq, e.xq);
    chk("sb_xh", xh, e.xh);
    chk("sb_running", {7'd0, running}, {7'd0, e.running});
    chk("sb_done", {7'd0, done}, {7'd0, e.done});
    chk("sb_expire", {7'd0, expire}, {7'd0, e.expire});
    chk("sb_warn", {7'd0, warn}, {7'd0, e.warn});
    chk("sb_load_err", {7'd0, load_err}, {7'd0, e.load_err});
  endtask

  task automatic run(input int n, input logic en, input logic md);
    repeat (n) step(1'b0, en, 1'b0, md, 8'h00, 8'h00);
  endtask

  initial begin
    // reset
    repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rst_xq", xq, 8'h01);
    chk("rst_xh", xh, 8'h00);
    chk("rst_flags", {3'd0, running, done, expire, warn, load_err}, 8'h00);

    // 01:05 counting through a minute boundary
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h01, 8'h05);
    chk("load_idle", {7'd0, running}, 8'h00);
    run(1, 1'b1, 1'b0);
    chk("run_entry", {7'd0, running}, 8'h01);
    run(4, 1'b1, 1'b0);
    chk("first_dec", xh, 8'h04);
    run(16, 1'b1, 1'b0);
    chk("t20_xq", xq, 8'h01);
    chk("t20_xh", xh, 8'h00);
    run(4, 1'b1, 1'b0);
    chk("t24_xq", xq, 8'h00);
    chk("t24_xh", xh, 8'h59);

    // reset mid-run
    step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("midrst_xq", xq, 8'h01);
    chk("midrst_run", {7'd0, running}, 8'h00);

    // 00:03 one-shot
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03);
    run(1, 1'b1, 1'b0);
    chk("os_warn", {7'd0, warn}, 8'h01);
    run(12, 1'b1, 1'b0);
    chk("os_expire", {7'd0, expire}, 8'h01);
    chk("os_done", {7'd0, done}, 8'h01);
    chk("os_warn0", {7'd0, warn}, 8'h00);
    run(20, 1'b1, 1'b0);
    chk("os_hold", {xq | xh}, 8'h00);
    chk("os_exp0", {7'd0, expire}, 8'h00);

    // 00:02 auto-reload
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h02);
    run(1, 1'b1, 1'b1);
    run(8, 1'b1, 1'b1);
    chk("ar_exp1", {7'd0, expire}, 8'h01);
    chk("ar_xh", xh, 8'h02);
    run(8, 1'b1, 1'b1);
    chk("ar_exp2", {7'd0, expire}, 8'h01);
    chk("ar_done", {7'd0, done}, 8'h00);

    // pause keeps the prescaler
    step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h05);
    run(1, 1'b1, 1'b0);
    run(2, 1'b1, 1'b0);
    run(10, 1'b0, 1'b0);
    chk("pause_frozen", xh, 8'h05);
    chk("pause_state", {7'd0, running}, 8'h00);
    run(1, 1'b1, 1'b0);
    chk("resume_1", xh, 8'h05);
    run(1, 1'b1, 1'b0);
    chk("resume_tick", xh, 8'h04);

    // rejected load while running
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h7A);
    chk("lerr_pulse", {7'd0, load_err}, 8'h01);
    chk("lerr_xh", xh, 8'h04);
    chk("lerr_run", {7'd0, running}, 8'h01);
    run(1, 1'b1, 1'b0);
    chk("lerr_clear", {7'd0, load_err}, 8'h00);

    // valid load on a tick cycle: presets win
    for (int i = 0; i < DIV && m_presc != DIV - 1; i++) run(1, 1'b1, 1'b0);
    chk("tick_align", 8'(m_presc), 8'(DIV - 1));
    step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h30);
    chk("ldtick_xh", xh, 8'h30);
    chk("ldtick_idle", {7'd0, running}, 8'h00);

    // random soak
    for (int i = 0; i < 400; i++) begin
      logic       r, en, ld, md;
      logic [7:0] mi, se;
      r  = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 7) != 0);
      ld = ($urandom_range(0, 15) == 0);
      md = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        mi = 8'($urandom_range(0, 255));
        se = 8'($urandom_range(0, 255));
      end else begin
        mi = {4'd0, 4'($urandom_range(0, 1))};
        se = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 9))};
      end
      step(r, en, ld, md, mi, se);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
